// File: rtl/music_pkg.sv
// music_pkg
//   Shared definitions for the tone sequencer: the playback state encoding and
//   the default parameter values used by tone_sequencer.
package music_pkg;

  localparam int MS_CYCLES_DEF = 50000;  // clocks per 1 ms at 50 MHz
  localparam int DEPTH_DEF     = 256;    // note-table entries
  localparam int HP_W_DEF      = 20;     // half-period width (clocks)
  localparam int DUR_W_DEF     = 16;     // duration width (ms)

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_PAUSED
  } state_t;

endpackage

// File: rtl/tone_gen.sv
// tone_gen
//   50% square-wave generator. While enabled and not held, it toggles its
//   output every `half` cycles. Hold freezes the counter and forces the output
//   low. Dropping enable clears the counter and the output phase, so every
//   note starts from a low output.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   enable         - tone active (counter cleared when low)
//   hold           - freeze counter, output forced low
//   half           - half period in clock cycles; 0 = rest (output low)
//   pwm            - tone output
module tone_gen #(
  parameter int HP_W = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            hold,
  input  logic [HP_W-1:0] half,
  output logic            pwm
);

  logic [HP_W-1:0] cnt;
  logic            phase;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!hold && half != '0) begin
      if (cnt == half - HP_W'(1)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + HP_W'(1);
      end
    end
  end

  // A rest never toggles phase, so no separate half==0 gating is needed.
  assign pwm = phase & enable & ~hold;

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Plays a song stored in an internal note table. Each entry holds a tone
//   half-period (0 = rest) and a duration in milliseconds. Playback walks
//   entries 0..song_len-1, optionally looping, with pause and abort control.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   wr_en/wr_addr/wr_half/wr_dur - note-table write port (any state)
//   song_len                   - notes to play, latched on start
//   start, pause, abort, loop_en - playback control
//   pwm                        - tone output
//   busy                       - playback in progress (not IDLE)
//   note_idx                   - index of the current note
//   done                       - one-cycle pulse as a non-looping song ends
module tone_sequencer
  import music_pkg::*;
#(
  parameter int MS_CYCLES = MS_CYCLES_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int HP_W      = HP_W_DEF,
  parameter int DUR_W     = DUR_W_DEF,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [HP_W-1:0]  wr_half,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic [AW:0]      song_len,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             loop_en,
  output logic             pwm,
  output logic             busy,
  output logic [AW-1:0]    note_idx,
  output logic             done
);

  localparam int TW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;

  state_t state_q, state_d;

  logic [HP_W-1:0]  mem_half [DEPTH];
  logic [DUR_W-1:0] mem_dur  [DEPTH];

  logic [AW:0]      len_q;
  logic [HP_W-1:0]  cur_half;
  logic [DUR_W-1:0] cur_dur;
  logic [TW-1:0]    tick_cnt;
  logic [DUR_W-1:0] dur_cnt;

  logic tick_wrap, note_end, last_note;

  // NOTE: the table has no reset; its contents must survive a reset and a
  // reset term would also stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_half[wr_addr] <= wr_half;
      mem_dur[wr_addr]  <= wr_dur;
    end
  end

  assign tick_wrap = (tick_cnt == TW'(MS_CYCLES - 1));
  // A zero-duration note ends after its single PLAY cycle.
  assign note_end  = (state_q == ST_PLAY) &&
                     ((cur_dur == '0) ||
                      (tick_wrap && dur_cnt == cur_dur - DUR_W'(1)));
  assign last_note = ({1'b0, note_idx} == len_q - (AW+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE:
        if (start && !abort && song_len != '0) state_d = ST_FETCH;
      ST_FETCH:
        state_d = abort ? ST_IDLE : ST_PLAY;
      ST_PLAY:
        if (abort) begin
          state_d = ST_IDLE;
        end else if (note_end) begin
          if (!last_note || loop_en) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
            done    = !reset;
          end
        end else if (pause) begin
          state_d = ST_PAUSED;
        end
      ST_PAUSED:
        if (abort)       state_d = ST_IDLE;
        else if (!pause) state_d = ST_PLAY;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Playback datapath. The FETCH read samples the table before any write in
  // the same cycle lands, so a colliding write is seen at the next fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      note_idx <= '0;
      len_q    <= '0;
      cur_half <= '0;
      cur_dur  <= '0;
      tick_cnt <= '0;
      dur_cnt  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE:
          if (state_d == ST_FETCH) begin
            note_idx <= '0;
            len_q    <= song_len;
          end
        ST_FETCH: begin
          cur_half <= mem_half[note_idx];
          cur_dur  <= mem_dur[note_idx];
          tick_cnt <= '0;
          dur_cnt  <= '0;
        end
        ST_PLAY:
          if (!abort) begin
            if (note_end) begin
              if (!last_note)   note_idx <= note_idx + AW'(1);
              else if (loop_en) note_idx <= '0;
            end else if (tick_wrap) begin
              tick_cnt <= '0;
              dur_cnt  <= dur_cnt + DUR_W'(1);
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        default: ;  // PAUSED holds every count
      endcase
    end
  end

  tone_gen #(.HP_W(HP_W)) u_tone (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == ST_PLAY || state_q == ST_PAUSED),
    .hold   (state_q == ST_PAUSED),
    .half   (cur_half),
    .pwm    (pwm)
  );

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer
//   Scoreboard bench for tone_sequencer (MS_CYCLES=10, DEPTH=8). The stimulus
//   side walks a song note by note, derives every cycle's expected outputs from
//   the note table (fetch cycle, then dur*10 play cycles with pwm=(k/half)%2)
//   and queues them; a negedge monitor pops and compares.
module tb_tone_sequencer;

  localparam int MS    = 10;
  localparam int DEPTH = 8;
  localparam int HP_W  = 20;
  localparam int DUR_W = 16;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [HP_W-1:0]  wr_half;
  logic [DUR_W-1:0] wr_dur;
  logic [AW:0]      song_len;
  logic             start, pause, abort, loop_en;
  logic             pwm, busy, done;
  logic [AW-1:0]    note_idx;

  typedef struct {
    logic busy;
    logic pwm;
    int   idx;
    logic done;
    int   tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   tab_h[DEPTH];
  int   tab_d[DEPTH];
  int   m_idx = 0;
  int   tag   = 0;

  tone_sequencer #(.MS_CYCLES(MS), .DEPTH(DEPTH), .HP_W(HP_W), .DUR_W(DUR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_half  (wr_half),
    .wr_dur   (wr_dur),
    .song_len (song_len),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .loop_en  (loop_en),
    .pwm      (pwm),
    .busy     (busy),
    .note_idx (note_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int tg,
                       input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s phase=%0d t=%0t: got %0d expected %0d", name, tg, $time, act, req);
    end
  endtask

  // Monitor: one expected record per DUT cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("busy",     e.tag, 32'(busy),     32'(e.busy));
        check("pwm",      e.tag, 32'(pwm),      32'(e.pwm));
        check("note_idx", e.tag, 32'(note_idx), e.idx);
        check("done",     e.tag, 32'(done),     32'(e.done));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic step(input logic b, input logic p, input int i, input logic d);
    exp_t e;
    e.busy = b; e.pwm = p; e.idx = i; e.done = d; e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, m_idx, 1'b0);
  endtask

  // Drive a table write for the coming cycle and update the reference table.
  task automatic set_write(input int a, input int h, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_half = HP_W'(h);
    wr_dur  = DUR_W'(d);
    tab_h[a] = h;
    tab_d[a] = d;
  endtask

  task automatic load(input int a, input int h, input int d);
    set_write(a, h, d);
    idle_cycles(1);
  endtask

  // Play nlen notes for `passes` passes (loop_en high on all but the last).
  // Optional events in pass 0: pause at (p_note,p_at) for p_len cycles,
  // abort at (a_note,a_at), reset at (r_note,r_at). rnd_wr adds random writes.
  task automatic play(input int nlen, input int passes,
                      input int p_note, input int p_at, input int p_len,
                      input int a_note, input int a_at,
                      input int r_note, input int r_at, input bit rnd_wr);
    song_len = 4'(nlen);
    loop_en  = (passes > 1);
    start    = 1'b1;
    step(1'b0, 1'b0, m_idx, 1'b0);
    for (int pass = 0; pass < passes; pass++) begin
      for (int n = 0; n < nlen; n++) begin
        int h, d, tk;
        loop_en = (pass < passes - 1);
        start   = 1'($urandom_range(0, 1));
        h = tab_h[n];
        d = tab_d[n];
        m_idx = n;
        // A write to the entry being fetched in this very cycle must not be seen.
        if (rnd_wr && $urandom_range(0, 3) == 0)
          set_write(n, $urandom_range(0, 7), $urandom_range(0, 2));
        step(1'b1, 1'b0, n, 1'b0);
        tk = (d == 0) ? 1 : d * MS;
        for (int k = 0; k < tk; k++) begin
          logic pw, last;
          pw   = (h == 0) ? 1'b0 : 1'((k / h) % 2);
          last = (k == tk - 1) && (n == nlen - 1) && (pass == passes - 1);
          if (rnd_wr && $urandom_range(0, 7) == 0)
            set_write($urandom_range(0, DEPTH - 1), $urandom_range(0, 7), $urandom_range(0, 2));
          if (pass == 0 && n == r_note && k == r_at) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0; wr_en = 1'b0; start = 1'b0; loop_en = 1'b0;
            m_idx = 0;
            return;
          end
          if (pass == 0 && n == a_note && k == a_at) begin
            abort = 1'b1;
            step(1'b1, pw, n, 1'b0);
            abort = 1'b0; start = 1'b0; loop_en = 1'b0;
            return;
          end
          if (pass == 0 && n == p_note && k == p_at) begin
            pause = 1'b1;
            step(1'b1, pw, n, 1'b0);
            for (int j = 0; j < p_len; j++) begin
              pause = (j < p_len - 1);
              step(1'b1, 1'b0, n, 1'b0);
            end
            pause = 1'b0;
          end else begin
            step(1'b1, pw, n, last);
          end
        end
      end
    end
    start   = 1'b0;
    loop_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_half = '0; wr_dur = '0;
    song_len = '0; start = 1'b0; pause = 1'b0; abort = 1'b0; loop_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin tab_h[i] = 0; tab_d[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    tag = 0;  // reset state
    idle_cycles(2);

    tag = 1;  // basic two-note song, then done and idle
    load(0, 3, 2);
    load(1, 0, 1);
    play(2, 1, -1, 0, 0, -1, 0, -1, 0, 1'b0);
    idle_cycles(3);

    tag = 2;  // looping, loop_en dropped in the final pass
    play(2, 3, -1, 0, 0, -1, 0, -1, 0, 1'b0);
    idle_cycles(2);

    tag = 3;  // 7-cycle pause inside note 0
    play(2, 1, 0, 5, 7, -1, 0, -1, 0, 1'b0);
    idle_cycles(2);

    tag = 4;  // abort during note 1, then start with abort held in IDLE
    play(2, 1, -1, 0, 0, 1, 4, -1, 0, 1'b0);
    idle_cycles(2);
    start = 1'b1; abort = 1'b1; song_len = 4'd2;
    idle_cycles(1);
    start = 1'b0; abort = 1'b0;
    idle_cycles(2);

    tag = 5;  // zero-duration entry between two notes; song_len=0 ignored
    load(1, 5, 0);
    load(2, 2, 1);
    play(3, 1, -1, 0, 0, -1, 0, -1, 0, 1'b0);
    idle_cycles(2);
    song_len = '0; start = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    idle_cycles(2);

    tag = 6;  // reset mid-play, restart without reloading
    play(3, 1, -1, 0, 0, -1, 0, 0, 7, 1'b0);
    idle_cycles(2);
    play(3, 1, -1, 0, 0, -1, 0, -1, 0, 1'b0);
    idle_cycles(2);

    for (int t = 0; t < 6; t++) begin  // random songs with concurrent writes
      int nl;
      tag = 7 + t;
      nl = $urandom_range(1, DEPTH);
      for (int a = 0; a < nl; a++) load(a, $urandom_range(0, 7), $urandom_range(0, 2));
      play(nl, $urandom_range(1, 2), -1, 0, 0, -1, 0, -1, 0, 1'b1);
      idle_cycles(2);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drain", tag, 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter MS_CYCLES, default 50000: clock cycles per 1 ms duration tick (50 MHz clock).
REQ-002 Parameter DEPTH, default 256: note-table entries; AW = clog2(DEPTH).
REQ-003 Parameter HP_W, default 20: half-period field width in clock cycles; 0 = rest.
REQ-004 Parameter DUR_W, default 16: duration field width in ms.
REQ-005 clk  in  1  system clock; one clock domain, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  note-table write strobe.
REQ-008 wr_addr  in  AW  write address.
REQ-009 wr_half  in  HP_W  half-period to store.
REQ-010 wr_dur  in  DUR_W  duration (ms) to store.
REQ-011 song_len  in  AW+1  number of notes to play (1..DEPTH); sampled on start.
REQ-012 start  in  1  begin playback from entry 0 (level or pulse; acted on in IDLE only).
REQ-013 pause  in  1  level; freezes playback while high.
REQ-014 abort  in  1  level; terminates playback.
REQ-015 loop_en  in  1  sampled at end of song: 1 = restart at entry 0.
REQ-016 pwm  out  1  50% square tone output.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 note_idx  out  AW  index of current note.
REQ-019 done  out  1  one-cycle pulse when song ends without looping.

Function
REQ-020 States SHALL be IDLE, FETCH, PLAY, PAUSED.
REQ-021 IDLE->FETCH when start=1, abort=0 and song_len!=0; note_idx<=0, song_len latched.
REQ-022 FETCH SHALL last exactly one cycle: synchronous table read of note_idx into current half/dur registers, then PLAY.
REQ-023 PLAY SHALL count MS_CYCLES-cycle ticks; note ends on the cycle the tick count reaches current dur; dur=0 ends after one PLAY cycle.
REQ-024 At note end with note_idx<latched_len-1: note_idx+1, ->FETCH.
REQ-025 At note end of last note: loop_en=1 -> note_idx<=0, ->FETCH; loop_en=0 -> ->IDLE, done=1 for that cycle.
REQ-026 PLAY with pause=1 ->PAUSED; tick and tone counters hold; pwm=0; pause=0 ->PLAY resuming exactly from held counts.
REQ-027 abort=1 in any non-IDLE state ->IDLE next cycle, pwm=0, done not asserted; abort beats pause, note end and start.
REQ-028 start while busy SHALL be ignored.
REQ-029 Tone: in PLAY with half!=0, pwm toggles every half cycles (period 2*half); half=0 -> pwm=0; tone counter and pwm reset to 0 at each FETCH.
REQ-030 Writes SHALL be accepted in every state; a write to the entry being played takes effect at its next fetch only.
REQ-031 Write and FETCH read of the same address in one cycle SHALL return the old data.
REQ-032 Tick counter width clog2(MS_CYCLES); duration counter DUR_W bits; no wrap beyond dur.

Reset
REQ-033 reset SHALL force IDLE, note_idx=0, pwm=0, busy=0, done=0, all counters 0; table contents are not cleared.
REQ-034 reset mid-playback SHALL take priority over every other input in that cycle.

Structure
REQ-035 Shared package music_pkg SHALL hold the state encoding and default parameter constants.
REQ-036 Sub-module tone_gen (enable, hold, half -> pwm) SHALL implement REQ-029; table is an inferred RAM inside tone_sequencer.

Verification (MS_CYCLES=10, DEPTH=8)
REQ-037 Load {half=3,dur=2},{0,1}, song_len=2, start -> pwm period 6 cycles for 20 cycles, then 10 cycles low, done pulse, busy=0.
REQ-038 Same song, loop_en=1 -> note_idx sequence 0,1,0,1..., done never asserted; loop_en=0 mid-song -> ends after entry 1.
REQ-039 pause high 7 cycles in note 0 -> pwm=0 during pause, note 0 lasts exactly 27 cycles total.
REQ-040 abort during note 1 -> IDLE next cycle, pwm=0, done=0; start with abort=1 in IDLE -> stays IDLE.
REQ-041 dur=0 entry between two notes -> occupies 1 FETCH + 1 PLAY cycle; song_len=0 start -> stays IDLE.
REQ-042 reset during PLAY, then start without reloading -> table intact, playback restarts at entry 0.
